serial_cmd_receive: RTL



---
 rtl/serial_cmd_pkg.sv | 35 +++
 rtl/uart_rx_byte.sv | 113 +++++++++++
 rtl/serial_cmd_receive.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_cmd_pkg.sv
// Shared constants and state types for the RS232 command receiver.
// Contents: frame header bytes, command codes, the payload length limit,
// the configuration reset defaults, and the parser and UART state enums.
package serial_cmd_pkg;

   localparam logic [7:0]  HDR0        = 8'hA5;
   localparam logic [7:0]  HDR1        = 8'h5A;

   localparam logic [7:0]  CMD_TIMESET = 8'h01;
   localparam logic [7:0]  CMD_RES     = 8'h02;
   localparam logic [7:0]  CMD_EN      = 8'h03;
   localparam logic [7:0]  CMD_SEND    = 8'h04;

   localparam logic [7:0]  MAX_LEN     = 8'd4;

   localparam logic [25:0] DEF_TIMESET = 26'd22000;
   localparam logic [8:0]  DEF_RES     = 9'd10;

   typedef enum logic [2:0] {
      HUNT_H0,
      HUNT_H1,
      GET_CMD,
      GET_LEN,
      GET_PAY,
      GET_CHK
   } parse_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   rs232_rx    : asynchronous serial input, idles high
//   byte_valid  : one-cycle pulse, byte_data holds a received byte
//   byte_data   : received byte (LSB arrives first on the line)
//   rx_ferr     : one-cycle pulse, the stop bit was sampled low
module uart_rx_byte
   import serial_cmd_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rs232_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       rx_ferr
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]       sync_q, sync_d;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], rs232_rx};
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            // Mid start bit: a line already back high was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               state_d = RX_IDLE;
               valid_d = rx_s;
               ferr_d  = !rx_s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = shift_q;
   assign rx_ferr    = ferr_q;

endmodule

// File: rtl/serial_cmd_receive.sv
// Host-to-device RS232 command receiver: parses A5 5A CMD LEN payload CHK
// frames and holds the runtime configuration they write.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   rs232_rx         : asynchronous serial input
//   timeSet          : sampling period configuration (26 bits)
//   resolution       : resolution configuration (9 bits)
//   enable           : sampling enable
//   serialsend_flag  : protocol send enable
//   cmd_ok / cmd_err : one-cycle frame accepted / rejected pulses
//   rx_ferr          : one-cycle UART framing error pulse
module serial_cmd_receive
   import serial_cmd_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 20
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rs232_rx,
   output logic [25:0] timeSet,
   output logic [8:0]  resolution,
   output logic        enable,
   output logic        serialsend_flag,
   output logic        cmd_ok,
   output logic        cmd_err,
   output logic        rx_ferr
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TMO_W        = $clog2(TMO_LIMIT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       ferr;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rs232_rx   (rs232_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .rx_ferr    (ferr)
   );

   parse_state_t     state_q, state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       len_q, len_d;
   logic [7:0]       pay_cnt_q, pay_cnt_d;
   // Only the low 26 payload bits can ever reach a configuration register,
   // so the upper bytes shifted past bit 25 are simply dropped.
   logic [25:0]      acc_q, acc_d;
   logic [7:0]       sum_q, sum_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [25:0]      timeset_q, timeset_d;
   logic [8:0]       res_q, res_d;
   logic             en_q, en_d;
   logic             send_q, send_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      len_d     = len_q;
      pay_cnt_d = pay_cnt_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      timeset_d = timeset_q;
      res_d     = res_q;
      en_d      = en_q;
      send_d    = send_q;
      ok_d      = 1'b0;
      err_d     = 1'b0;

      // Idle time only matters while a frame is partly received.
      if (byte_valid || state_q == HUNT_H0) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      if (ferr) begin
         state_d = HUNT_H0;
      end else if (byte_valid) begin
         case (state_q)
            HUNT_H0: begin
               if (byte_data == HDR0) state_d = HUNT_H1;
            end
            HUNT_H1: begin
               // A repeated A5 may itself be the start of the real header.
               if (byte_data == HDR1)      state_d = GET_CMD;
               else if (byte_data == HDR0) state_d = HUNT_H1;
               else                        state_d = HUNT_H0;
            end
            GET_CMD: begin
               cmd_d   = byte_data;
               sum_d   = byte_data;
               state_d = GET_LEN;
            end
            GET_LEN: begin
               len_d     = byte_data;
               sum_d     = sum_q + byte_data;
               acc_d     = '0;
               pay_cnt_d = '0;
               if (byte_data == 8'd0) begin
                  state_d = GET_CHK;
               end else if (byte_data > MAX_LEN) begin
                  err_d   = 1'b1;
                  state_d = HUNT_H0;
               end else begin
                  state_d = GET_PAY;
               end
            end
            GET_PAY: begin
               acc_d     = {acc_q[17:0], byte_data};
               sum_d     = sum_q + byte_data;
               pay_cnt_d = pay_cnt_q + 8'd1;
               if (pay_cnt_d == len_q) state_d = GET_CHK;
            end
            GET_CHK: begin
               state_d = HUNT_H0;
               if (byte_data != sum_q) begin
                  err_d = 1'b1;
               end else if (cmd_q == CMD_TIMESET && len_q == 8'd4) begin
                  timeset_d = acc_q;
                  ok_d      = 1'b1;
               end else if (cmd_q == CMD_RES && len_q == 8'd2) begin
                  res_d = acc_q[8:0];
                  ok_d  = 1'b1;
               end else if (cmd_q == CMD_EN && len_q == 8'd1) begin
                  en_d = acc_q[0];
                  ok_d = 1'b1;
               end else if (cmd_q == CMD_SEND && len_q == 8'd1) begin
                  send_d = acc_q[0];
                  ok_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = HUNT_H0;
         endcase
      end else if (state_q != HUNT_H0 && tmo_q == TMO_LAST) begin
         err_d   = 1'b1;
         state_d = HUNT_H0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT_H0;
         cmd_q     <= '0;
         len_q     <= '0;
         pay_cnt_q <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         timeset_q <= DEF_TIMESET;
         res_q     <= DEF_RES;
         en_q      <= 1'b1;
         send_q    <= 1'b1;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         len_q     <= len_d;
         pay_cnt_q <= pay_cnt_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         tmo_q     <= tmo_d;
         timeset_q <= timeset_d;
         res_q     <= res_d;
         en_q      <= en_d;
         send_q    <= send_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
      end
   end

   assign timeSet         = timeset_q;
   assign resolution      = res_q;
   assign enable          = en_q;
   assign serialsend_flag = send_q;
   assign cmd_ok          = ok_q;
   assign cmd_err         = err_q;
   assign rx_ferr         = ferr;

endmodule
